// File: rtl/fifo_param_buffer_pkg.sv
// rtl/fifo_param_buffer_pkg.sv - status flag bundle and flag derivation for the parametrised FIFO
package fifo_param_buffer_pkg;

    // All occupancy-derived flags travel together so they are always registered from one count.
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // Flag values held while in reset (empty store).
    localparam fifo_status_t FIFO_STATUS_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    // Derive every flag from a single occupancy value.
    function automatic fifo_status_t fifo_status(
        input int unsigned count,
        input int unsigned depth,
        input int unsigned af_thresh,
        input int unsigned ae_thresh
    );
        fifo_status_t s;
        s.empty        = (count == 0);
        s.full         = (count == depth);
        s.almost_full  = (count >= af_thresh);
        s.almost_empty = (count <= ae_thresh);
        return s;
    endfunction

endpackage

// File: rtl/fifo_defs.vh
// rtl/fifo_defs.vh - width derivation and parameter range checks shared by FIFO variants
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

// Pointer width: one bit per address line of a power-of-two store.
`define FIFO_AW(depth) $clog2(depth)

// Occupancy width: one extra bit so a completely full store (count == depth) is representable.
`define FIFO_CNT_W(depth) ($clog2(depth) + 1)

// Depth must be a power of two so the pointers wrap by natural rollover.
`define FIFO_DEPTH_OK(depth) (((depth) >= 4) && (((depth) & ((depth) - 1)) == 0))

// Almost-full threshold has to sit strictly between empty and full.
`define FIFO_AF_OK(af, depth) (((af) >= 1) && ((af) <= ((depth) - 1)))

// Almost-empty threshold must leave at least two levels above it.
`define FIFO_AE_OK(ae, depth) (((ae) >= 0) && ((ae) <= ((depth) - 2)))

`endif

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - simple dual-port store: synchronous write, asynchronous read address path
module fifo_sdp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the control logic never reads an unwritten entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param_buffer.sv
// rtl/fifo_param_buffer.sv - parametrised synchronous FIFO with thresholds and standard/FWFT read
`include "fifo_defs.vh"

module fifo_param_buffer
    import fifo_param_buffer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = 56,
    parameter int AE_THRESH = 8,
    parameter int FWFT      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             buf_in,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             buf_out,
    output logic                          rd_valid,
    output logic                          buf_empty,
    output logic                          buf_full,
    output logic                          buf_almost_full,
    output logic                          buf_almost_empty,
    output logic                          overflow,
    output logic                          underflow,
    output logic [`FIFO_CNT_W(DEPTH)-1:0] fifo_counter
);

    localparam int AW    = `FIFO_AW(DEPTH);
    localparam int CNT_W = `FIFO_CNT_W(DEPTH);

    // Refuse to elaborate with parameters the pointer/flag logic cannot honour.
    generate
        if (!`FIFO_DEPTH_OK(DEPTH)) begin : g_bad_depth
            $error("fifo_param_buffer: DEPTH must be a power of two and at least 4");
        end
        if (!`FIFO_AF_OK(AF_THRESH, DEPTH)) begin : g_bad_af
            $error("fifo_param_buffer: AF_THRESH must lie in 1..DEPTH-1");
        end
        if (!`FIFO_AE_OK(AE_THRESH, DEPTH)) begin : g_bad_ae
            $error("fifo_param_buffer: AE_THRESH must lie in 0..DEPTH-2");
        end
    endgenerate

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              rd_ok;
    logic              wr_ok;
    logic [CNT_W-1:0]  count_next;
    fifo_status_t      status_next;
    logic [DATA_W-1:0] ram_rd_data;

    // A read frees a slot in the same cycle, so a full FIFO still takes a simultaneous write.
    assign rd_ok       = rd_en & ~buf_empty;
    assign wr_ok       = wr_en & (~buf_full | rd_ok);
    assign count_next  = fifo_counter + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    assign status_next = fifo_status(32'(count_next), DEPTH, AF_THRESH, AE_THRESH);

    // Pointers, occupancy, flags and error pulses; flags follow the next count so they track fifo_counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fifo_counter     <= '0;
            buf_empty        <= FIFO_STATUS_RESET.empty;
            buf_full         <= FIFO_STATUS_RESET.full;
            buf_almost_full  <= FIFO_STATUS_RESET.almost_full;
            buf_almost_empty <= FIFO_STATUS_RESET.almost_empty;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_counter     <= count_next;
            buf_empty        <= status_next.empty;
            buf_full         <= status_next.full;
            buf_almost_full  <= status_next.almost_full;
            buf_almost_empty <= status_next.almost_empty;
            overflow         <= wr_en & ~wr_ok;
            underflow        <= rd_en & ~rd_ok;
        end
    end

    // Writes are gated by reset so a request in a reset cycle leaves no trace.
    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok & rst),
        .wr_addr (wr_ptr),
        .wr_data (buf_in),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    generate
        if (FWFT == 0) begin : g_std_read
            // Standard read: capture the head on an accepted read and flag it for exactly one cycle.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    buf_out  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_ok;
                    if (rd_ok) begin
                        buf_out <= ram_rd_data;
                    end
                end
            end
        end else begin : g_fwft_read
            // Fall-through: the head is always presented; forced to zero while nothing is stored.
            always_comb begin
                buf_out  = buf_empty ? '0 : ram_rd_data;
                rd_valid = ~buf_empty;
            end
        end
    endgenerate

endmodule
